axi_mm_slave: RTL and testbench

// - AXI4 memory-mapped slave (64-bit data), on-chip word RAM behind the M_AXI_* bus driven by an external master.
// - Endpoint of the AXI-MM cache subsystem; independent write (AW/W/B) and read (AR/R) engines.
// - Upper address bits ignored: 0x0000_0000+n and 0x8000_0000+n alias to the same RAM word.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_mem_ram.sv | 39 +++
 rtl/axi_mm_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_mm_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared constants and FSM state types for the AXI4 memory-mapped slave.
//   BURST_*  : AxBURST encodings accepted by the slave
//   SIZE_8B  : the only AxSIZE served (64-bit beats)
//   RESP_*   : xRESP encodings returned on B and R
//   burst_ok : 1 when a size/burst pair can be served
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size == SIZE_8B) && (burst == BURST_FIXED || burst == BURST_INCR);
  endfunction
endpackage

// File: rtl/axi_mem_ram.sv
// Word RAM, DEPTH x DATA_W, one byte-enabled write port and one registered
// read port. The read register only loads when re_i is high, so read data
// stays put while the consumer stalls.
//   clk_i, rst_ni        : clock, async active-low reset (read register only)
//   we_i/waddr_i/wstrb_i/wdata_i : write port
//   re_i/raddr_i/rdata_o : read port, data valid the cycle after re_i
module axi_mem_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    waddr_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  // Non-blocking update means a same-cycle write is not seen by this read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_mm_slave.sv
// AXI4 memory-mapped slave in front of an on-chip word RAM. Independent write
// (AW/W/B) and read (AR/R) engines, one outstanding burst each. Only 8-byte
// beats with FIXED or INCR bursts are served; anything else completes with
// SLVERR and touches no RAM. Address bits above the RAM index are ignored.
//   clk, rst_n      : clock, async active-low reset
//   M_AXI_AW*/W*/B* : write address, data and response channels
//   M_AXI_AR*/R*    : read address and data channels
module axi_mm_slave
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  input  logic [7:0]                  M_AXI_AWLEN,
  input  logic [2:0]                  M_AXI_AWSIZE,
  input  logic [1:0]                  M_AXI_AWBURST,
  input  logic                        M_AXI_AWVALID,
  output logic                        M_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WLAST,
  output logic                        M_AXI_WREADY,
  output logic [1:0]                  M_AXI_BRESP,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
  output logic                        M_AXI_BVALID,
  input  logic                        M_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  input  logic [7:0]                  M_AXI_ARLEN,
  input  logic [2:0]                  M_AXI_ARSIZE,
  input  logic [1:0]                  M_AXI_ARBURST,
  input  logic                        M_AXI_ARVALID,
  output logic                        M_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
  output logic [1:0]                  M_AXI_RRESP,
  output logic                        M_AXI_RLAST,
  output logic                        M_AXI_RVALID,
  input  logic                        M_AXI_RREADY
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int AW    = AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BEAT_BYTES = AW'(8);

  // Holds both AxREADYs low until the first clock after reset release.
  logic en_q;

  w_state_t              w_state_q, w_state_d;
  logic [AW-1:0]         w_addr_q, w_addr_d;
  logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                  w_fixed_q, w_fixed_d, w_bad_q, w_bad_d, w_lerr_q, w_lerr_d;

  r_state_t              r_state_q, r_state_d;
  logic [AW-1:0]         r_addr_q, r_addr_d, r_addr_nxt;
  logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                  r_fixed_q, r_fixed_d, r_bad_q, r_bad_d;

  logic                  ram_we, ram_re;
  logic [IDX_W-1:0]      ram_raddr;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_bad_q   <= 1'b0;
      w_lerr_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_bad_q   <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_bad_q   <= w_bad_d;
      w_lerr_q  <= w_lerr_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_bad_q   <= r_bad_d;
    end
  end

  // Write engine
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_bad_d   = w_bad_q;
    w_lerr_d  = w_lerr_q;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    ram_we        = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        M_AXI_AWREADY = en_q;
        if (M_AXI_AWVALID && en_q) begin
          w_addr_d  = M_AXI_AWADDR;
          w_id_d    = M_AXI_AWID;
          w_len_d   = M_AXI_AWLEN;
          w_cnt_d   = '0;
          w_fixed_d = (M_AXI_AWBURST == BURST_FIXED);
          w_bad_d   = !burst_ok(M_AXI_AWSIZE, M_AXI_AWBURST);
          w_lerr_d  = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        M_AXI_WREADY = 1'b1;
        if (M_AXI_WVALID) begin
          // Bad size/burst still drains the beats, it just never writes.
          ram_we   = !w_bad_q;
          w_lerr_d = w_lerr_q | (M_AXI_WLAST != (w_cnt_q == w_len_q));
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            if (!w_fixed_q) w_addr_d = w_addr_q + BEAT_BYTES;
          end
        end
      end
      W_RESP: begin
        M_AXI_BVALID = 1'b1;
        if (M_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign M_AXI_BRESP = (M_AXI_BVALID && (w_bad_q || w_lerr_q)) ? RESP_SLVERR : RESP_OKAY;
  assign M_AXI_BID   = w_id_q;

  // Read engine. The RAM read is launched on the AR handshake or on an
  // accepted non-last beat, so the registered data lines up with RVALID.
  assign r_addr_nxt = r_fixed_q ? r_addr_q : r_addr_q + BEAT_BYTES;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_bad_d   = r_bad_q;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    ram_re        = 1'b0;
    ram_raddr     = r_addr_q[3 +: IDX_W];
    unique case (r_state_q)
      R_IDLE: begin
        M_AXI_ARREADY = en_q;
        if (M_AXI_ARVALID && en_q) begin
          r_addr_d  = M_AXI_ARADDR;
          r_id_d    = M_AXI_ARID;
          r_len_d   = M_AXI_ARLEN;
          r_cnt_d   = '0;
          r_fixed_d = (M_AXI_ARBURST == BURST_FIXED);
          r_bad_d   = !burst_ok(M_AXI_ARSIZE, M_AXI_ARBURST);
          ram_re    = 1'b1;
          ram_raddr = M_AXI_ARADDR[3 +: IDX_W];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        M_AXI_RVALID = 1'b1;
        if (M_AXI_RREADY) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            r_addr_d  = r_addr_nxt;
            ram_re    = 1'b1;
            ram_raddr = r_addr_nxt[3 +: IDX_W];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign M_AXI_RLAST = M_AXI_RVALID && (r_cnt_q == r_len_q);
  assign M_AXI_RRESP = (M_AXI_RVALID && r_bad_q) ? RESP_SLVERR : RESP_OKAY;
  assign M_AXI_RDATA = (M_AXI_RVALID && !r_bad_q) ? ram_rdata : '0;
  assign M_AXI_RID   = r_id_q;

  // Byte-offset and alias bits of the addresses play no part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_q[AW-1:3+IDX_W], w_addr_q[2:0],
                              r_addr_q[AW-1:3+IDX_W], r_addr_q[2:0],
                              r_addr_nxt[AW-1:3+IDX_W], r_addr_nxt[2:0],
                              M_AXI_ARADDR[AW-1:3+IDX_W], M_AXI_ARADDR[2:0]};

  axi_mem_ram #(.DEPTH(MEM_DEPTH), .DATA_W(AXI_DATA_WIDTH), .IDX_W(IDX_W)) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (ram_we),
    .waddr_i (w_addr_q[3 +: IDX_W]),
    .wstrb_i (M_AXI_WSTRB),
    .wdata_i (M_AXI_WDATA),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_axi_mm_slave.sv
// Directed bench for axi_mm_slave: bus-driver tasks plus one task per feature
// with hand-computed expectations.
module tb_axi_mm_slave;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [3:0]  AWID = '0, ARID = '0, BID, RID;
  logic [7:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic        AWVALID = 0, AWREADY, WVALID = 0, WLAST = 0, WREADY;
  logic        BVALID, BREADY = 0, ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;
  logic [63:0] WDATA = '0, RDATA;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  axi_mm_slave dut (
    .clk(clk), .rst_n(rst_n),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWID(AWID), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WLAST(WLAST),
    .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP), .M_AXI_BID(BID), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARID(ARID), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RID(RID), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // ---------------- bus drivers ----------------
  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    @(negedge clk);
    AWADDR = a; AWID = id; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1;
    while (!AWREADY && n < TMO) begin @(negedge clk); n++; end
    if (!AWREADY) begin n_chk++; n_fail++; $display("FAIL aw_timeout: awready=0 required 1"); end
    else @(posedge clk);
    #1 AWVALID = 0;
  endtask

  task automatic send_w(input logic [7:0] len, input logic [63:0] d0, input logic [63:0] dinc,
                        input logic [7:0] strb, input int last_at);
    for (int b = 0; b <= int'(len); b++) begin
      int n = 0;
      @(negedge clk);
      WDATA = d0 + 64'(b) * dinc; WSTRB = strb; WLAST = (b == last_at); WVALID = 1;
      while (!WREADY && n < TMO) begin @(negedge clk); n++; end
      if (!WREADY) begin n_chk++; n_fail++; $display("FAIL w_timeout: wready=0 required 1"); end
      else @(posedge clk);
      #1 WVALID = 0; WLAST = 0;
    end
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    @(negedge clk);
    while (!BVALID && n < TMO) begin @(negedge clk); n++; end
    if (!BVALID) begin
      n_chk++; n_fail++; $display("FAIL b_timeout: bvalid=0 required 1");
      resp = 2'bxx; id = 4'bxxxx;
    end else begin
      resp = BRESP; id = BID; BREADY = 1;
      @(posedge clk); #1 BREADY = 0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                    input logic [2:0] sz, input logic [1:0] bu, input logic [63:0] d0,
                    input logic [63:0] dinc, input logic [7:0] strb, input int last_at,
                    output logic [1:0] resp, output logic [3:0] bid);
    send_aw(a, id, len, sz, bu);
    send_w(len, d0, dinc, strb, last_at);
    get_b(resp, bid);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    @(negedge clk);
    ARADDR = a; ARID = id; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1;
    while (!ARREADY && n < TMO) begin @(negedge clk); n++; end
    if (!ARREADY) begin n_chk++; n_fail++; $display("FAIL ar_timeout: arready=0 required 1"); end
    else @(posedge clk);
    #1 ARVALID = 0;
  endtask

  task automatic get_r(output logic [63:0] d, output logic [1:0] resp,
                       output logic [3:0] id, output logic last);
    int n = 0;
    @(negedge clk);
    while (!RVALID && n < TMO) begin @(negedge clk); n++; end
    if (!RVALID) begin
      n_chk++; n_fail++; $display("FAIL r_timeout: rvalid=0 required 1");
      d = 'x; resp = 2'bxx; id = 4'bxxxx; last = 1'bx;
    end else begin
      d = RDATA; resp = RRESP; id = RID; last = RLAST; RREADY = 1;
      @(posedge clk); #1 RREADY = 0;
    end
  endtask

  task automatic rd1(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                     output logic last);
    logic [3:0] id;
    send_ar(a, 4'h7, 8'd0, 3'd3, 2'b01);
    get_r(d, resp, id, last);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 000000",
                         {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
    end
    n_chk++;
    if ({BRESP, RRESP, BID, RID, RDATA} !== '0) begin
      n_fail++; $display("FAIL reset_payload: bresp=%b rresp=%b bid=%h rid=%h rdata=%h expected all 0",
                         BRESP, RRESP, BID, RID, RDATA);
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_chk++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release: aw/arready=%b expected 11", {AWREADY, ARREADY});
    end
  endtask

  task automatic test_single_write();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    wr(32'h0, 4'h0, 8'd0, 3'd3, 2'b01, 64'h0, 64'h0, 8'hFF, 0, resp, id);
    n_chk++;
    if ({resp, id} !== {2'b00, 4'h0}) begin
      n_fail++; $display("FAIL single_w0: bresp=%b bid=%h expected 00 0", resp, id);
    end
    wr(32'h4, 4'h1, 8'd0, 3'd3, 2'b01, 64'h4, 64'h0, 8'hFF, 0, resp, id);
    n_chk++;
    if ({resp, id} !== {2'b00, 4'h1}) begin
      n_fail++; $display("FAIL single_w1: bresp=%b bid=%h expected 00 1", resp, id);
    end
    rd1(32'h0, d, resp, last);
    n_chk++;
    if (d !== 64'h4) begin n_fail++; $display("FAIL single_rd: rdata=%h expected 4", d); end
  endtask

  task automatic test_alias();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    wr(32'h8, 4'h2, 8'd0, 3'd3, 2'b01, 64'h1122334455667788, 64'h0, 8'hFF, 0, resp, id);
    rd1(32'h8000_0008, d, resp, last);
    n_chk++;
    if ({d, last, resp} !== {64'h1122334455667788, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL alias_rd: rdata=%h rlast=%b rresp=%b expected 1122334455667788 1 00",
                         d, last, resp);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d, d0; logic last; logic stable; int n;
    wr(32'h100, 4'h3, 8'd3, 3'd3, 2'b01, 64'h1, 64'h1, 8'hFF, 3, resp, id);
    n_chk++;
    if ({resp, id} !== {2'b00, 4'h3}) begin
      n_fail++; $display("FAIL incr_b: bresp=%b bid=%h expected 00 3", resp, id);
    end
    send_ar(32'h100, 4'h5, 8'd3, 3'd3, 2'b01);
    // stall the first beat and watch it stay put
    n = 0;
    @(negedge clk);
    while (!RVALID && n < TMO) begin @(negedge clk); n++; end
    d0 = RDATA; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (RDATA !== d0 || RVALID !== 1'b1 || RLAST !== 1'b0) stable = 1'b0;
    end
    n_chk++;
    if (!stable || d0 !== 64'h1) begin
      n_fail++; $display("FAIL incr_hold: rdata=%h stable=%b expected 1 1", d0, stable);
    end
    for (int b = 0; b < 4; b++) begin
      get_r(d, resp, id, last);
      n_chk++;
      if ({d, last, id, resp} !== {64'(b + 1), (b == 3), 4'h5, 2'b00}) begin
        n_fail++; $display("FAIL incr_beat%0d: rdata=%h rlast=%b rid=%h rresp=%b expected %h %b 5 00",
                           b, d, last, id, resp, 64'(b + 1), (b == 3));
      end
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    wr(32'h200, 4'h0, 8'd0, 3'd3, 2'b01, '1, 64'h0, 8'hFF, 0, resp, id);
    wr(32'h200, 4'h0, 8'd0, 3'd3, 2'b01, 64'h0, 64'h0, 8'h0F, 0, resp, id);
    rd1(32'h200, d, resp, last);
    n_chk++;
    if (d !== 64'hFFFFFFFF00000000) begin
      n_fail++; $display("FAIL wstrb: rdata=%h expected ffffffff00000000", d);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    wr(32'h300, 4'h0, 8'd0, 3'd3, 2'b01, 64'hA5A5A5A5A5A5A5A5, 64'h0, 8'hFF, 0, resp, id);
    wr(32'h300, 4'h4, 8'd0, 3'd2, 2'b01, 64'h0, 64'h0, 8'hFF, 0, resp, id);
    n_chk++;
    if ({resp, id} !== {2'b10, 4'h4}) begin
      n_fail++; $display("FAIL err_size: bresp=%b bid=%h expected 10 4", resp, id);
    end
    wr(32'h300, 4'h6, 8'd1, 3'd3, 2'b10, 64'h0, 64'h0, 8'hFF, 1, resp, id);
    n_chk++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL err_burst: bresp=%b expected 10", resp); end
    rd1(32'h300, d, resp, last);
    n_chk++;
    if (d !== 64'hA5A5A5A5A5A5A5A5) begin
      n_fail++; $display("FAIL err_ram_kept: rdata=%h expected a5a5a5a5a5a5a5a5", d);
    end
    send_ar(32'h300, 4'h9, 8'd0, 3'd2, 2'b01);
    get_r(d, resp, id, last);
    n_chk++;
    if ({d, resp, last, id} !== {64'h0, 2'b10, 1'b1, 4'h9}) begin
      n_fail++; $display("FAIL err_arsize: rdata=%h rresp=%b rlast=%b rid=%h expected 0 10 1 9",
                         d, resp, last, id);
    end
    wr(32'h308, 4'h0, 8'd1, 3'd3, 2'b01, 64'h0, 64'h0, 8'hFF, 0, resp, id);
    n_chk++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL err_early_last: bresp=%b expected 10", resp); end
    wr(32'h308, 4'h0, 8'd0, 3'd3, 2'b01, 64'h0, 64'h0, 8'hFF, 5, resp, id);
    n_chk++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL err_no_last: bresp=%b expected 10", resp); end
  endtask

  task automatic test_b_hold();
    logic [1:0] resp; logic [3:0] id; logic stable;
    send_aw(32'h310, 4'hA, 8'd0, 3'd3, 2'b01);
    send_w(8'd0, 64'h77, 64'h0, 8'hFF, 0);
    stable = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (BVALID !== 1'b1 || BID !== 4'hA) stable = 1'b0;
    end
    n_chk++;
    if (!stable) begin n_fail++; $display("FAIL b_hold: bvalid/bid dropped, stable=%b expected 1", stable); end
    get_b(resp, id);
    n_chk++;
    if ({resp, id} !== {2'b00, 4'hA}) begin
      n_fail++; $display("FAIL b_hold_resp: bresp=%b bid=%h expected 00 a", resp, id);
    end
  endtask

  task automatic test_wrap_fixed();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    // INCR from the top word rolls over to word 0
    wr(32'h1FF8, 4'h0, 8'd1, 3'd3, 2'b01, 64'hAA, 64'h1, 8'hFF, 1, resp, id);
    rd1(32'h0, d, resp, last);
    n_chk++;
    if (d !== 64'hAB) begin n_fail++; $display("FAIL wrap_low: rdata=%h expected ab", d); end
    rd1(32'h1FF8, d, resp, last);
    n_chk++;
    if (d !== 64'hAA) begin n_fail++; $display("FAIL wrap_top: rdata=%h expected aa", d); end
    // FIXED keeps hitting one word; last beat wins
    wr(32'h400, 4'h0, 8'd2, 3'd3, 2'b00, 64'h10, 64'h1, 8'hFF, 2, resp, id);
    send_ar(32'h400, 4'h2, 8'd1, 3'd3, 2'b00);
    for (int b = 0; b < 2; b++) begin
      get_r(d, resp, id, last);
      n_chk++;
      if ({d, last} !== {64'h12, (b == 1)}) begin
        n_fail++; $display("FAIL fixed_beat%0d: rdata=%h rlast=%b expected 12 %b", b, d, last, (b == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alias();
    test_incr_burst();
    test_wstrb();
    test_errors();
    test_b_hold();
    test_wrap_fixed();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
